// File: rtl/clock_mode_ctrl_if.sv
// Handshake bundle between the input stage, the mode controller and the field counters.
// The master side drives the debounced controls; the slave side is the controller.
interface clock_mode_ctrl_if #(
   parameter int NFIELDS = 3,
   parameter int SEL_W   = 3
);
   logic               adj;
   logic               sel_next;
   logic               pause_tog;
   logic               inc_btn;
   logic               tick_2hz;
   logic               use_1hz;
   logic               use_2hz;
   logic               count_enable;
   logic               paused;
   logic               blink_enable;
   logic [SEL_W-1:0]   field_idx;
   logic [NFIELDS-1:0] field_sel;
   logic               inc_pulse;

   modport master (
      output adj, sel_next, pause_tog, inc_btn, tick_2hz,
      input  use_1hz, use_2hz, count_enable, paused, blink_enable,
             field_idx, field_sel, inc_pulse
   );

   modport slave (
      input  adj, sel_next, pause_tog, inc_btn, tick_2hz,
      output use_1hz, use_2hz, count_enable, paused, blink_enable,
             field_idx, field_sel, inc_pulse
   );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Run/pause/adjust mode controller with field select and increment strobe.
// Define AUTO_REPEAT_EN to add hold-to-repeat on inc_btn, paced by tick_2hz.
module clock_mode_ctrl #(
   parameter int NFIELDS    = 3,
   parameter int SEL_W      = 3,
   parameter int REPEAT_DLY = 3
) (
   input logic           clk,
   input logic           rst,
   clock_mode_ctrl_if.slave bus
);
   if (NFIELDS < 2 || NFIELDS > 8) begin : g_bad_nfields
      $error("clock_mode_ctrl: NFIELDS out of range");
   end
   if ((2 ** SEL_W) < NFIELDS) begin : g_bad_sel_w
      $error("clock_mode_ctrl: SEL_W too narrow for NFIELDS");
   end
   if (REPEAT_DLY < 1 || REPEAT_DLY > 15) begin : g_bad_dly
      $error("clock_mode_ctrl: REPEAT_DLY out of range");
   end

   typedef enum logic [1:0] {RUN, PAUSE, ADJ} state_t;

   state_t           state;
   logic             ret;        // 1: ADJ was entered from PAUSE
   logic [SEL_W-1:0] field_idx;
   logic             inc_q;
   logic             inc_pulse;
   logic             in_adj;
   logic             stay_adj;
   logic             inc_edge;
   logic             field_adv;
   logic             rpt_hit;

   assign in_adj    = (state == ADJ);
   // Qualifying with adj squashes any strobe that would land after the exit cycle
   assign stay_adj  = in_adj && bus.adj;
   assign inc_edge  = bus.inc_btn && !inc_q;
   assign field_adv = stay_adj && bus.sel_next;

`ifdef AUTO_REPEAT_EN
   logic [3:0] rpt_cnt;
   logic       rpt_sat;

   assign rpt_sat = (rpt_cnt == 4'(REPEAT_DLY));
   assign rpt_hit = stay_adj && bus.inc_btn && bus.tick_2hz && rpt_sat;

   always_ff @(posedge clk) begin
      if (rst)
         rpt_cnt <= '0;
      else if (!stay_adj || !bus.inc_btn || field_adv)
         rpt_cnt <= '0;
      else if (bus.tick_2hz && !rpt_sat)
         rpt_cnt <= rpt_cnt + 4'd1;
   end
`else
   assign rpt_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         ret       <= 1'b0;
         field_idx <= '0;
         inc_q     <= 1'b0;
         inc_pulse <= 1'b0;
      end else begin
         // Edge register tracks inc_btn in every mode so a press held across ADJ entry is not an edge
         inc_q     <= bus.inc_btn;
         inc_pulse <= stay_adj && (inc_edge || rpt_hit);
         case (state)
            RUN: begin
               if (bus.pause_tog)
                  state <= PAUSE;
               else if (bus.adj) begin
                  state     <= ADJ;
                  ret       <= 1'b0;
                  field_idx <= '0;
               end
            end
            PAUSE: begin
               if (bus.pause_tog)
                  state <= RUN;
               else if (bus.adj) begin
                  state     <= ADJ;
                  ret       <= 1'b1;
                  field_idx <= '0;
               end
            end
            ADJ: begin
               if (!bus.adj)
                  state <= ret ? PAUSE : RUN;
               else if (bus.sel_next)
                  field_idx <= (field_idx == SEL_W'(NFIELDS - 1)) ? '0 : field_idx + 1'b1;
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.use_1hz      = !in_adj;
   assign bus.use_2hz      = in_adj;
   assign bus.count_enable = (state == RUN) && !bus.adj;
   assign bus.paused       = (state == PAUSE) || (in_adj && ret);
   assign bus.blink_enable = in_adj && !bus.inc_btn;
   assign bus.field_idx    = field_idx;
   assign bus.inc_pulse    = inc_pulse;

   for (genvar i = 0; i < NFIELDS; i++) begin : g_sel
      assign bus.field_sel[i] = in_adj && (field_idx == SEL_W'(i));
   end
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed and randomized checks of clock_mode_ctrl against a cycle-level behavioural model.
module tb_clock_mode_ctrl;
   localparam int NF  = 3;
   localparam int SW  = 3;
   localparam int DLY = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   clock_mode_ctrl_if #(.NFIELDS(NF), .SEL_W(SW)) bus();

   clock_mode_ctrl #(.NFIELDS(NF), .SEL_W(SW), .REPEAT_DLY(DLY)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errs   = 0;
   int checks = 0;
   int pulses = 0;

   // Reference model: mode 0=run 1=pause 2=adjust
   int m_mode;
   bit m_from_pause;
   int m_field;
   bit m_pulse;
   bit m_prev_inc;
   int m_held_ticks;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_from_pause = 0; m_field = 0;
      m_pulse = 0; m_prev_inc = 0; m_held_ticks = 0;
   endtask

   task automatic model_check();
      bit in_adj;
      in_adj = (m_mode == 2);
      chk("use_1hz",   bus.use_1hz,      !in_adj);
      chk("use_2hz",   bus.use_2hz,      in_adj);
      chk("count_en",  bus.count_enable, (m_mode == 0) && !bus.adj);
      chk("paused",    bus.paused,       (m_mode == 1) || (in_adj && m_from_pause));
      chk("blink",     bus.blink_enable, in_adj && !bus.inc_btn);
      chk("field_idx", bus.field_idx,    m_field);
      chk("field_sel", bus.field_sel,    in_adj ? (1 << m_field) : 0);
      chk("inc_pulse", bus.inc_pulse,    m_pulse);
   endtask

   // Advance the model one clock using the inputs present at that edge
   task automatic model_step();
      bit a, s, p, i, t, active, np;
      a = bus.adj; s = bus.sel_next; p = bus.pause_tog; i = bus.inc_btn; t = bus.tick_2hz;
      active = (m_mode == 2) && a;
      np = active && i && !m_prev_inc;
`ifdef AUTO_REPEAT_EN
      if (active && i && t && m_held_ticks >= DLY) np = 1;
      if (active && i && !s) begin
         if (t && m_held_ticks < DLY) m_held_ticks++;
      end else
         m_held_ticks = 0;
`endif
      case (m_mode)
         0: if (p) m_mode = 1; else if (a) begin m_mode = 2; m_from_pause = 0; m_field = 0; end
         1: if (p) m_mode = 0; else if (a) begin m_mode = 2; m_from_pause = 1; m_field = 0; end
         default: if (!a) m_mode = m_from_pause ? 1 : 0;
                  else if (s) m_field = (m_field + 1) % NF;
      endcase
      m_prev_inc = i;
      m_pulse = np;
   endtask

   // Apply inputs just after an edge, check mid-cycle, then clock
   task automatic step(input bit a, input bit s, input bit p, input bit i, input bit t);
      bus.adj = a; bus.sel_next = s; bus.pause_tog = p; bus.inc_btn = i; bus.tick_2hz = t;
      #3;
      model_check();
      if (bus.inc_pulse === 1'b1) pulses++;
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      int exp_idx[4];
      int exp_sel[4];
      bit a, s, p, i, t;
      exp_idx = '{1, 2, 0, 1};
      exp_sel = '{2, 4, 1, 2};

      bus.adj = 0; bus.sel_next = 0; bus.pause_tog = 0; bus.inc_btn = 0; bus.tick_2hz = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      chk("rst_use_1hz",   bus.use_1hz, 1);
      chk("rst_count_en",  bus.count_enable, 1);
      chk("rst_field_sel", bus.field_sel, 0);
      chk("rst_inc_pulse", bus.inc_pulse, 0);
      chk("rst_paused",    bus.paused, 0);

      // pause, adjust from pause, return to pause
      step(0, 0, 1, 0, 0);
      chk("t2_paused", bus.paused, 1);
      chk("t2_count_en", bus.count_enable, 0);
      step(1, 0, 0, 0, 0);
      chk("t2_adj_sel", bus.field_sel, 3'b001);
      chk("t2_adj_paused", bus.paused, 1);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("t2_back_paused", bus.paused, 1);
      chk("t2_back_1hz", bus.use_1hz, 1);
      step(0, 0, 1, 0, 0);
      chk("t2_run_count_en", bus.count_enable, 1);

      // field select wrap
      step(1, 1, 0, 0, 0);
      chk("t3_entry_idx", bus.field_idx, 0);
      for (int k = 0; k < 4; k++) begin
         step(1, 1, 0, 0, 0);
         chk("t3_idx", bus.field_idx, exp_idx[k]);
         chk("t3_sel", bus.field_sel, exp_sel[k]);
      end

      // three single-cycle presses
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         step(1, 0, 0, 1, 0);
         chk("t4_blink_held", bus.blink_enable, 0);
         step(1, 0, 0, 0, 0);
         step(1, 0, 0, 0, 0);
      end
      chk("t4_pulses", pulses, 3);

      // pause wins over adj; pause_tog ignored in adjust
      step(0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0);
      chk("t5_pause_wins", bus.paused, 1);
      chk("t5_not_adj", bus.use_2hz, 0);
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0);
      chk("t5_stay_adj", bus.use_2hz, 1);
      chk("t5_adj_run_ret", bus.paused, 0);
      step(0, 0, 0, 0, 0);

      // button already held at adjust entry does not strobe
      pulses = 0;
      step(0, 0, 0, 1, 0);
      repeat (3) step(1, 0, 0, 1, 0);
      chk("held_entry_pulses", pulses, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("repress_pulses", pulses, 1);

      // long hold with ticks, then drop adj mid-hold
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         step(1, 0, 0, 1, 1);
         step(1, 0, 0, 1, 0);
         step(1, 0, 0, 1, 0);
      end
`ifdef AUTO_REPEAT_EN
      chk("t6_hold_pulses", pulses, 6);
`else
      chk("t6_hold_pulses", pulses, 1);
`endif
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 1, 1);
         step(0, 0, 0, 1, 0);
      end
      chk("t6_after_exit", pulses, 0);
      step(0, 0, 0, 0, 0);

      // randomized traffic
      a = 0; i = 0;
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 19) == 0) a = !a;
         if ($urandom_range(0, 4) == 0) i = !i;
         s = ($urandom_range(0, 5) == 0);
         p = ($urandom_range(0, 9) == 0);
         t = ($urandom_range(0, 2) == 0);
         step(a, s, p, i, t);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
